input_data_feeder: RTL and testbench
====================================

// Module: input_data_feeder
// PURPOSE
// - Responder for the conv2d core's input-data request port: each o_data_req pulse
//   from the core is answered, in order, with one NUM_CHANNEL-pixel word on i_data/i_data_vld.
// - Reads the input feature map from an on-chip buffer at consecutive addresses from a
//   configured base, wraps at the configured size, and drains when the core raises o_data_end.
// - Sits between the input buffer memory controller and accelerator_core.
// PARAMETERS
// - BIT_WIDTH        8   bits per channel sample
// - NUM_CHANNEL      3   channels per output word (o_data = BIT_WIDTH*NUM_CHANNEL bits)
// - ADDR_WIDTH       32  memory address width
// - DATA_WIDTH       32  memory word width (>= BIT_WIDTH*NUM_CHANNEL)
// - REG_WIDTH        32  config/status register width
// - MAX_OUTSTANDING  8   max in-flight memory reads; pending counter is clog2(MAX_OUTSTANDING+1) bits
// PORTS
// - clk            in   1                       clock
// - rst_n          in   1                       reset, asynchronous, active-low
// - i_data_req     in   1                       one-cycle pulse per word requested (core o_data_req)
// - i_data_end     in   1                       core finished requesting (core o_data_end)
// - o_data         out  BIT_WIDTH*NUM_CHANNEL   pixel word to core i_data
// - o_data_vld     out  1                       o_data valid, one cycle per word
// - mem_radd       out  ADDR_WIDTH              buffer read address
// - mem_rden       out  1                       buffer read enable
// - mem_odat       in   DATA_WIDTH              buffer read data
// - mem_ovld       in   1                       buffer read data valid
// - i_conf_ctrl    in   REG_WIDTH               [0] enable, [1] soft reset
// - i_conf_inbase  in   REG_WIDTH               word address of first pixel
// - i_conf_insize  in   REG_WIDTH               words per pass (>=1)
// - o_pass_cnt     out  REG_WIDTH               completed passes (wraps)
// - o_err_ovf      out  1                       sticky: request arrived with MAX_OUTSTANDING pending
// - o_done         out  1                       drain complete
// BEHAVIOUR
// - Reset (rst_n=0): all outputs 0, state IDLE, idx=0, pending=0, discard=0.
// - FSM: IDLE -> RUN when enable=1 and soft reset=0. RUN -> DRAIN on i_data_end.
//   DRAIN -> DONE when pending==0. DONE holds o_done=1 until enable=0 -> IDLE.
// - Enable=0 or soft reset=1 in any state: next cycle IDLE, idx/pass_cnt/o_err_ovf cleared,
//   discard<=pending; subsequent discard mem_ovld beats decrement discard, produce no o_data_vld.
// - RUN: i_data_req at cycle N -> mem_rden=1, mem_radd=inbase+idx at N+1 (registered);
//   idx<=idx+1, pending+1. If idx==insize-1: idx<=0, o_pass_cnt+1.
// - Return: mem_ovld at cycle M -> o_data=mem_odat[BIT_WIDTH*NUM_CHANNEL-1:0], o_data_vld=1
//   at M+1; pending-1. o_data holds last value when o_data_vld=0. Order preserved.
// - Total latency req->o_data_vld = 2 + memory delay cycles.
// - Same-cycle request issue and return: pending unchanged.
// - i_data_req with pending==MAX_OUTSTANDING: request dropped, o_err_ovf<=1 (sticky).
// - i_data_req in IDLE, DRAIN or DONE: ignored, no read issued.
// - i_data_req and i_data_end same cycle in RUN: request served, then DRAIN.
// - mem_ovld with pending==0 and discard==0: ignored.
// - Address arithmetic modulo 2^ADDR_WIDTH; insize==0 treated as 1.
// TESTING
// - base=0x100,size=4, 4 reqs (mem delay 1) -> radd 0x100..0x103, 4 vld beats 3 cycles after each req, pass_cnt=1.
// - size=3, 7 back-to-back reqs -> radd 0,1,2,0,1,2,0; pass_cnt=2; 7 vld beats in order.
// - 8 reqs with memory stalled -> 9th req dropped, o_err_ovf=1, only 8 vld beats after release.
// - i_data_end with 3 pending -> o_done rises 1 cycle after 3rd return; enable=0 -> o_done=0.
// - enable dropped with 2 pending -> 2 late mem_ovld beats give no o_data_vld; rerun starts at idx 0.
// - rst_n asserted mid-RUN -> all outputs 0 immediately, restart reads from inbase.

Source files
------------

// File: rtl/input_data_feeder.sv
// input_data_feeder: answers each pixel-word request from the conv2d core.
// It issues one buffer read per request at inbase + idx, wrapping idx at insize.
// Returned words go back to the core in order, and the block drains on i_data_end.
// Reads still in flight when the block is stopped are discarded as they return.
module input_data_feeder #(
  parameter int BIT_WIDTH       = 8,
  parameter int NUM_CHANNEL     = 3,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int REG_WIDTH       = 32,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_data_req,
  input  logic                             i_data_end,
  output logic [BIT_WIDTH*NUM_CHANNEL-1:0] o_data,
  output logic                             o_data_vld,
  output logic [ADDR_WIDTH-1:0]            mem_radd,
  output logic                             mem_rden,
  input  logic [DATA_WIDTH-1:0]            mem_odat,
  input  logic                             mem_ovld,
  input  logic [REG_WIDTH-1:0]             i_conf_ctrl,
  input  logic [REG_WIDTH-1:0]             i_conf_inbase,
  input  logic [REG_WIDTH-1:0]             i_conf_insize,
  output logic [REG_WIDTH-1:0]             o_pass_cnt,
  output logic                             o_err_ovf,
  output logic                             o_done
);

  localparam int OUT_W  = BIT_WIDTH * NUM_CHANNEL;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  // Discard can collect the pending reads of more than one stop, so it gets one extra bit.
  localparam int DISC_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] MAX_PEND = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [REG_WIDTH-1:0]  r_idx;
  logic [REG_WIDTH-1:0]  r_pass_cnt;
  logic [CNT_W-1:0]      r_pending;
  logic [DISC_W-1:0]     r_discard;
  logic                  r_err_ovf;
  logic [OUT_W-1:0]      r_data;
  logic                  r_data_vld;
  logic [ADDR_WIDTH-1:0] r_mem_radd;
  logic                  r_mem_rden;

  logic                  w_stop;
  logic                  w_req_run;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_ret_disc;
  logic                  w_ret_live;
  logic [REG_WIDTH-1:0]  w_size;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [CNT_W-1:0]      w_pending_after;
  logic [DISC_W-1:0]     w_discard_after;
  logic                  w_unused;

  // Disabling the block or asserting soft reset both force it back to IDLE.
  assign w_stop     = ~i_conf_ctrl[0] | i_conf_ctrl[1];

  // Requests count only in RUN. A full pending counter turns a request into an overflow.
  assign w_req_run  = (r_state == ST_RUN) & ~w_stop & i_data_req;
  assign w_accept   = w_req_run & (r_pending != MAX_PEND);
  assign w_drop     = w_req_run & (r_pending == MAX_PEND);

  // Discarded reads were issued before any live read, so they always return first.
  assign w_ret_disc = mem_ovld & (r_discard != '0);
  assign w_ret_live = mem_ovld & (r_discard == '0) & (r_pending != '0);

  // A zero size behaves as a one-word pass. The compare is >= so that idx still wraps
  // if software shrinks the size in the middle of a pass.
  assign w_size     = (i_conf_insize == '0) ? REG_WIDTH'(1) : i_conf_insize;
  assign w_last     = (r_idx >= (w_size - REG_WIDTH'(1)));
  assign w_rd_addr  = ADDR_WIDTH'(i_conf_inbase) + ADDR_WIDTH'(r_idx);

  assign w_pending_after = r_pending + CNT_W'(w_accept) - CNT_W'(w_ret_live);
  assign w_discard_after = r_discard - DISC_W'(w_ret_disc);

  assign w_unused = ^{mem_odat[DATA_WIDTH-1:OUT_W], i_conf_ctrl[REG_WIDTH-1:2]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and the drain-complete flag.
  always_comb begin
    w_state_nxt = r_state;
    o_done      = 1'b0;
    if (r_state == ST_DONE) begin
      o_done = 1'b1;
    end
    if (w_stop) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_RUN;
        ST_RUN:   if (i_data_end) w_state_nxt = ST_DRAIN;
        ST_DRAIN: if (r_pending == '0) w_state_nxt = ST_DONE;
        ST_DONE:  w_state_nxt = ST_DONE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Register the read request: one read-enable pulse per accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_rden <= 1'b0;
      r_mem_radd <= '0;
    end else begin
      r_mem_rden <= w_accept;
      if (w_accept) begin
        r_mem_radd <= w_rd_addr;
      end
    end
  end

  // Read index and pass counter. A stop clears both so the next run starts at inbase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_pass_cnt <= '0;
    end else if (w_stop) begin
      r_idx      <= '0;
      r_pass_cnt <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_idx      <= '0;
        r_pass_cnt <= r_pass_cnt + REG_WIDTH'(1);
      end else begin
        r_idx      <= r_idx + REG_WIDTH'(1);
      end
    end
  end

  // Track live and discarded reads. On a stop, every live read becomes one to discard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_discard <= '0;
    end else if (w_stop) begin
      r_pending <= '0;
      r_discard <= w_discard_after + DISC_W'(w_pending_after);
    end else begin
      r_pending <= w_pending_after;
      r_discard <= w_discard_after;
    end
  end

  // Sticky overflow flag. It is cleared only by a stop or by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_ovf <= 1'b0;
    end else if (w_stop) begin
      r_err_ovf <= 1'b0;
    end else if (w_drop) begin
      r_err_ovf <= 1'b1;
    end
  end

  // Pass live returned words to the core. The data holds between beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data     <= '0;
      r_data_vld <= 1'b0;
    end else begin
      r_data_vld <= w_ret_live;
      if (w_ret_live) begin
        r_data <= mem_odat[OUT_W-1:0];
      end
    end
  end

  assign o_data     = r_data;
  assign o_data_vld = r_data_vld;
  assign mem_radd   = r_mem_radd;
  assign mem_rden   = r_mem_rden;
  assign o_pass_cnt = r_pass_cnt;
  assign o_err_ovf  = r_err_ovf;

endmodule

// File: tb/tb_input_data_feeder.sv
// Directed testbench for input_data_feeder.
// The memory model answers reads one cycle after mem_rden and can be stalled.
module tb_input_data_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_data_req = 1'b0;
  logic        i_data_end = 1'b0;
  logic [23:0] o_data;
  logic        o_data_vld;
  logic [31:0] mem_radd;
  logic        mem_rden;
  logic [31:0] mem_odat = '0;
  logic        mem_ovld = 1'b0;
  logic [31:0] i_conf_ctrl = '0;
  logic [31:0] i_conf_inbase = '0;
  logic [31:0] i_conf_insize = '0;
  logic [31:0] o_pass_cnt;
  logic        o_err_ovf;
  logic        o_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int doneCyc = -1;
  logic memStall = 1'b0;

  logic [31:0] memQ[$];
  logic [31:0] raddQ[$];
  logic [23:0] vldQ[$];
  int          vldCycQ[$];
  int          reqCycQ[$];

  input_data_feeder dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_data_req(i_data_req),
    .i_data_end(i_data_end),
    .o_data(o_data),
    .o_data_vld(o_data_vld),
    .mem_radd(mem_radd),
    .mem_rden(mem_rden),
    .mem_odat(mem_odat),
    .mem_ovld(mem_ovld),
    .i_conf_ctrl(i_conf_ctrl),
    .i_conf_inbase(i_conf_inbase),
    .i_conf_insize(i_conf_insize),
    .o_pass_cnt(o_pass_cnt),
    .o_err_ovf(o_err_ovf),
    .o_done(o_done)
  );

  always #5 clk = ~clk;

  // Cycle counter used to time-stamp requests and output beats.
  always @(posedge clk) cyc = cyc + 1;

  // Contents of the input buffer: a fixed pattern derived from each address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[7:0] ^ 8'hC3, a[7:0] + 8'h11, a[15:8] ^ 8'h5A, a[7:0]};
  endfunction

  function automatic logic [23:0] expData(input logic [31:0] a);
    logic [31:0] w;
    w = memWord(a);
    return w[23:0];
  endfunction

  // Monitor and memory model. Each read returns one cycle after its mem_rden is seen.
  always @(negedge clk) begin
    if (o_data_vld) begin
      vldQ.push_back(o_data);
      vldCycQ.push_back(cyc);
    end
    if (mem_rden) raddQ.push_back(mem_radd);
    if (o_done && doneCyc < 0) doneCyc = cyc;
    if (!memStall && memQ.size() > 0) begin
      mem_ovld = 1'b1;
      mem_odat = memWord(memQ.pop_front());
    end else begin
      mem_ovld = 1'b0;
    end
    if (mem_rden) memQ.push_back(mem_radd);
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setConfig(input logic [31:0] ctrl, input logic [31:0] base, input logic [31:0] size);
    @(negedge clk);
    i_conf_ctrl   = ctrl;
    i_conf_inbase = base;
    i_conf_insize = size;
  endtask

  // Issue n back-to-back one-cycle request pulses.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(negedge clk);
      i_data_req = 1'b1;
      reqCycQ.push_back(cyc);
    end
    @(negedge clk);
    i_data_req = 1'b0;
  endtask

  task automatic clearLogs();
    raddQ.delete();
    vldQ.delete();
    vldCycQ.delete();
    reqCycQ.delete();
    doneCyc = -1;
  endtask

  task automatic checkAddrAt(input string tag, input int i, input logic [31:0] exp);
    logic [31:0] a;
    a = (i < raddQ.size()) ? raddQ[i] : 32'hDEAD_BEEF;
    checkOutput(tag, a, exp);
  endtask

  task automatic checkDataAt(input string tag, input int i, input logic [31:0] addr);
    logic [31:0] d;
    d = (i < vldQ.size()) ? {8'h00, vldQ[i]} : 32'hDEAD_BEEF;
    checkOutput(tag, d, {8'h00, expData(addr)});
  endtask

  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, "_data"}, {8'h00, o_data}, 32'h0);
    checkOutput({pfx, "_vld"}, {31'h0, o_data_vld}, 32'h0);
    checkOutput({pfx, "_radd"}, mem_radd, 32'h0);
    checkOutput({pfx, "_rden"}, {31'h0, mem_rden}, 32'h0);
    checkOutput({pfx, "_pass"}, o_pass_cnt, 32'h0);
    checkOutput({pfx, "_ovf"}, {31'h0, o_err_ovf}, 32'h0);
    checkOutput({pfx, "_done"}, {31'h0, o_done}, 32'h0);
  endtask

  // Watchdog so the run cannot hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] seq3 [7];
    seq3 = '{32'd0, 32'd1, 32'd2, 32'd0, 32'd1, 32'd2, 32'd0};

    // Reset state
    waitCycles(3);
    checkAllZero("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: base 0x100, size 4, four requests with a one-cycle memory
    clearLogs();
    setConfig(32'h1, 32'h100, 32'd4);
    applyStimulus(4);
    waitCycles(10);
    checkOutput("t1_rdcount", raddQ.size(), 32'd4);
    checkOutput("t1_vldcount", vldQ.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkAddrAt($sformatf("t1_radd%0d", i), i, 32'h100 + i);
      checkDataAt($sformatf("t1_data%0d", i), i, 32'h100 + i);
      checkOutput($sformatf("t1_lat%0d", i),
                  (i < vldCycQ.size() && i < reqCycQ.size()) ? vldCycQ[i] - reqCycQ[i] : -1, 32'd3);
    end
    checkOutput("t1_pass", o_pass_cnt, 32'd1);

    // Test 2: size 3, seven back-to-back requests, so idx wraps twice
    setConfig(32'h0, 32'h0, 32'd3);
    waitCycles(2);
    clearLogs();
    setConfig(32'h1, 32'h0, 32'd3);
    applyStimulus(7);
    waitCycles(10);
    checkOutput("t2_vldcount", vldQ.size(), 32'd7);
    for (int i = 0; i < 7; i++) begin
      checkAddrAt($sformatf("t2_radd%0d", i), i, seq3[i]);
      checkDataAt($sformatf("t2_data%0d", i), i, seq3[i]);
    end
    checkOutput("t2_pass", o_pass_cnt, 32'd2);

    // Test 3: memory stalled, nine requests, so the ninth overflows
    setConfig(32'h0, 32'h200, 32'd16);
    waitCycles(2);
    clearLogs();
    memStall = 1'b1;
    setConfig(32'h1, 32'h200, 32'd16);
    applyStimulus(9);
    waitCycles(3);
    checkOutput("t3_rdcount", raddQ.size(), 32'd8);
    checkOutput("t3_ovf", {31'h0, o_err_ovf}, 32'h1);
    checkOutput("t3_vld_stalled", vldQ.size(), 32'd0);
    memStall = 1'b0;
    waitCycles(15);
    checkOutput("t3_vldcount", vldQ.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      checkDataAt($sformatf("t3_data%0d", i), i, 32'h200 + i);
    end

    // Test 4: i_data_end with three reads pending, then drain completes
    clearLogs();
    memStall = 1'b1;
    applyStimulus(3);
    @(negedge clk);
    i_data_end = 1'b1;
    @(negedge clk);
    i_data_end = 1'b0;
    waitCycles(3);
    checkOutput("t4_done_early", {31'h0, o_done}, 32'h0);
    memStall = 1'b0;
    waitCycles(8);
    checkOutput("t4_vldcount", vldQ.size(), 32'd3);
    checkOutput("t4_done", {31'h0, o_done}, 32'h1);
    checkOutput("t4_done_delay", (vldCycQ.size() >= 3) ? doneCyc - vldCycQ[2] : -100, 32'd1);
    applyStimulus(1);
    waitCycles(3);
    checkOutput("t4_req_in_done", raddQ.size(), 32'd3);
    checkOutput("t4_ovf_sticky", {31'h0, o_err_ovf}, 32'h1);
    setConfig(32'h0, 32'h200, 32'd16);
    waitCycles(1);
    checkOutput("t4_done_clr", {31'h0, o_done}, 32'h0);
    checkOutput("t4_ovf_clr", {31'h0, o_err_ovf}, 32'h0);

    // Test 5: stop with two reads in flight; the rerun must see only its own data
    clearLogs();
    memStall = 1'b1;
    setConfig(32'h1, 32'h300, 32'd8);
    applyStimulus(2);
    waitCycles(2);
    setConfig(32'h0, 32'h380, 32'd8);
    waitCycles(2);
    setConfig(32'h1, 32'h380, 32'd8);
    applyStimulus(1);
    waitCycles(2);
    memStall = 1'b0;
    waitCycles(10);
    checkOutput("t5_rdcount", raddQ.size(), 32'd3);
    checkAddrAt("t5_rerun_radd", 2, 32'h380);
    checkOutput("t5_vldcount", vldQ.size(), 32'd1);
    checkDataAt("t5_rerun_data", 0, 32'h380);

    // Test 6: async reset in the middle of RUN, then restart from inbase
    setConfig(32'h0, 32'h400, 32'd2);
    waitCycles(2);
    clearLogs();
    setConfig(32'h1, 32'h400, 32'd2);
    memStall = 1'b1;
    applyStimulus(3);
    waitCycles(1);
    checkOutput("t6_pass_before", o_pass_cnt, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkAllZero("t6_rst");
    memStall = 1'b0;
    waitCycles(6);
    checkOutput("t6_vld_in_rst", vldQ.size(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clearLogs();
    waitCycles(2);
    applyStimulus(2);
    waitCycles(8);
    checkOutput("t6_rdcount", raddQ.size(), 32'd2);
    checkAddrAt("t6_radd0", 0, 32'h400);
    checkAddrAt("t6_radd1", 1, 32'h401);
    checkOutput("t6_vldcount", vldQ.size(), 32'd2);
    checkDataAt("t6_data0", 0, 32'h400);
    checkDataAt("t6_data1", 1, 32'h401);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
